// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: handles a cache miss by issuing one pipelined read per
// cycle for every word of the block. It counts the read-return strobes and
// streams each returned word into the data array. The tag is written on the
// last return. When the controller is idle it forwards write-through stores.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no fill active; forwards write-through stores, accepts misses
// S_ISSUE | one block read per cycle; early returns may already arrive
// S_DRAIN | all reads issued; waiting for the remaining returns
module cache_fill_ctrl #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 16,
  parameter int WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [AWIDTH-1:0]        miss_address,
  input  logic                     wt_req,
  input  logic [AWIDTH-1:0]        wt_addr,
  input  logic [DWIDTH-1:0]        wt_data,
  output logic                     wt_ack,
  output logic                     fsm_busy,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [AWIDTH-1:0]        mem_addr,
  output logic [DWIDTH-1:0]        mem_data_in,
  input  logic [DWIDTH-1:0]        mem_data_out,
  input  logic                     mem_data_valid,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic [DWIDTH-1:0]        fill_data,
  output logic                     write_tag_array
);

  localparam int WIDX = $clog2(WORDS);
  localparam int CW   = WIDX + 1;
  localparam logic [AWIDTH-1:0] OFFSET_MASK = AWIDTH'(2 * WORDS - 1);
  localparam logic [CW-1:0]     LAST        = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWIDTH-1:0] r_base_addr;
  logic [CW-1:0]     r_issue_cnt;
  logic [CW-1:0]     r_recv_cnt;
  logic              w_accept;

  // Store data and fill data are straight pass-throughs.
  assign mem_data_in = wt_data;
  assign fill_data   = mem_data_out;

  // State register, latched block base and the issue/return counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_base_addr <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_base_addr <= miss_address & ~OFFSET_MASK;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else begin
        if (r_state == S_ISSUE) r_issue_cnt <= r_issue_cnt + 1'b1;
        if (write_data_array)   r_recv_cnt  <= r_recv_cnt + 1'b1;
      end
    end
  end

  // Next state plus all outputs. Outputs are held low while reset is asserted.
  always_comb begin
    w_state_nxt      = r_state;
    w_accept         = 1'b0;
    wt_ack           = 1'b0;
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    write_tag_array  = 1'b0;
    if (!rst) begin
      fsm_busy = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          // A pending store takes priority. The miss waits one more idle cycle.
          if (wt_req) begin
            wt_ack     = 1'b1;
            mem_enable = 1'b1;
            mem_wr     = 1'b1;
            mem_addr   = wt_addr;
          end else if (miss_detected) begin
            w_accept    = 1'b1;
            w_state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_enable = 1'b1;
          mem_addr   = r_base_addr + AWIDTH'({r_issue_cnt[WIDX-1:0], 1'b0});
          if (r_issue_cnt == LAST) w_state_nxt = S_DRAIN;
        end
        S_DRAIN: begin
          mem_enable = 1'b0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
      // Returns are counted and do not depend on latency. A zero-latency
      // memory could deliver the last word during the final issue cycle.
      if ((r_state != S_IDLE) && mem_data_valid) begin
        write_data_array = 1'b1;
        fill_word        = r_recv_cnt[WIDX-1:0];
        if ((r_recv_cnt == LAST) &&
            ((r_state == S_DRAIN) || (r_issue_cnt == LAST))) begin
          write_tag_array = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl. The memory model returns each read
// after a programmable latency. Reads of the upper half of a block can be
// given extra delay, which opens a gap in the return stream.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        wt_req;
  logic [15:0] wt_addr;
  logic [15:0] wt_data;
  logic        wt_ack;
  logic        fsm_busy;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic        write_data_array;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        write_tag_array;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr;

  always #5 clk = ~clk;

  cache_fill_ctrl #(.DWIDTH(16), .AWIDTH(16), .WORDS(8)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .wt_req(wt_req), .wt_addr(wt_addr), .wt_data(wt_data), .wt_ack(wt_ack),
    .fsm_busy(fsm_busy), .mem_enable(mem_enable), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_data_valid(mem_data_valid),
    .write_data_array(write_data_array), .fill_word(fill_word),
    .fill_data(fill_data), .write_tag_array(write_tag_array)
  );

  // Memory model: a read issued in cycle k returns in cycle k+lat (+gap).
  int          mem_lat   = 4;
  int          mem_gap   = 0;
  logic        inj_valid = 1'b0;
  logic [4:0]  mcyc      = '0;
  logic [4:0]  m_d;
  logic        slot_v [0:31];
  logic [15:0] slot_a [0:31];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) slot_v[i] <= 1'b0;
    end else begin
      slot_v[mcyc] <= 1'b0;
      if (mem_enable && !mem_wr) begin
        m_d = 5'(mem_lat + ((mem_addr[3:1] >= 3'd4) ? mem_gap : 0));
        slot_v[mcyc + m_d] <= 1'b1;
        slot_a[mcyc + m_d] <= mem_addr;
      end
    end
    mcyc <= mcyc + 5'd1;
  end

  assign mem_data_valid = slot_v[mcyc] | inj_valid;
  assign mem_data_out   = slot_a[mcyc] ^ 16'h5A5A;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, fsm_busy, 0);
    chk({tag, "_en"},   mem_enable, 0);
    chk({tag, "_wr"},   mem_wr, 0);
    chk({tag, "_ack"},  wt_ack, 0);
    chk({tag, "_wda"},  write_data_array, 0);
    chk({tag, "_tag"},  write_tag_array, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_fw"},   fill_word, 0);
  endtask

  task automatic step_begin();
    @(posedge clk);
    #1;
  endtask

  // Checks cycles 1..13 of a 4-cycle-latency fill whose miss was accepted
  // in cycle 0.
  task automatic check_fill(input string tag, input logic [15:0] base,
                            input bit keep, input logic [15:0] next_addr);
    logic wda;
    for (int c = 1; c <= 13; c++) begin
      step_begin();
      if (keep && c == 1) miss_address = next_addr;
      if (!keep && c == 12) miss_detected = 1'b0;
      @(negedge clk);
      wda = (c >= 5 && c <= 12);
      chk({tag, "_busy"}, fsm_busy, (c <= 12));
      chk({tag, "_en"},   mem_enable, (c <= 8));
      chk({tag, "_wr"},   mem_wr, 0);
      if (c <= 8) chk({tag, "_addr"}, mem_addr, 16'(base + 16'(2 * (c - 1))));
      chk({tag, "_wda"}, write_data_array, wda);
      if (wda) begin
        chk({tag, "_fw"}, fill_word, c - 5);
        chk({tag, "_fd"}, fill_data, 16'(base + 16'(2 * (c - 5))) ^ 16'h5A5A);
      end
      chk({tag, "_tag"}, write_tag_array, (c == 12));
    end
  endtask

  initial begin
    rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
    wt_req = 1'b0; wt_addr = '0; wt_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle("rst_hold");
    step_begin(); rst = 1'b0;
    @(negedge clk);
    chk_idle("rst_rel");

    // Write-through while idle
    step_begin(); wt_req = 1'b1; wt_addr = 16'h00A4; wt_data = 16'hBEEF;
    @(negedge clk);
    chk("wt_en",   mem_enable, 1);
    chk("wt_wr",   mem_wr, 1);
    chk("wt_addr", mem_addr, 16'h00A4);
    chk("wt_ack",  wt_ack, 1);
    chk("wt_data", mem_data_in, 16'hBEEF);
    chk("wt_busy", fsm_busy, 0);
    step_begin(); wt_req = 1'b0;
    @(negedge clk);
    chk("wt_done_en", mem_enable, 0);
    chk("wt_done_ack", wt_ack, 0);

    // A stray return strobe while idle must not write the array.
    step_begin(); inj_valid = 1'b1;
    @(negedge clk);
    chk("idle_valid_wda", write_data_array, 0);
    chk("idle_valid_tag", write_tag_array, 0);
    chk("idle_valid_busy", fsm_busy, 0);
    step_begin(); inj_valid = 1'b0;

    // Basic fill at 0x1236 (block 0x1230)
    step_begin(); miss_detected = 1'b1; miss_address = 16'h1236;
    @(negedge clk);
    chk("fill_c0_busy", fsm_busy, 0);
    chk("fill_c0_en", mem_enable, 0);
    check_fill("fill", 16'h1230, 1'b0, 16'h0);

    // Collision: store and miss together; the store goes first
    step_begin();
    wt_req = 1'b1; wt_addr = 16'h0040; wt_data = 16'h1111;
    miss_detected = 1'b1; miss_address = 16'h2000;
    @(negedge clk);
    chk("col_ack0", wt_ack, 1);
    chk("col_wr0", mem_wr, 1);
    chk("col_addr0", mem_addr, 16'h0040);
    chk("col_busy0", fsm_busy, 0);
    step_begin(); wt_req = 1'b0;
    @(negedge clk);
    chk("col_busy1", fsm_busy, 0);
    chk("col_en1", mem_enable, 0);
    step_begin(); wt_req = 1'b1; wt_addr = 16'h0050; wt_data = 16'h2222;
    @(negedge clk);
    chk("col_busy2", fsm_busy, 1);
    chk("col_en2", mem_enable, 1);
    chk("col_wr2", mem_wr, 0);
    chk("col_addr2", mem_addr, 16'h2000);
    chk("col_ack2", wt_ack, 0);
    for (int c = 3; c <= 14; c++) begin
      step_begin();
      if (c == 3) miss_detected = 1'b0;
      @(negedge clk);
      chk("col_ack", wt_ack, (c == 14));
      chk("col_busy", fsm_busy, (c <= 13));
      chk("col_tag", write_tag_array, (c == 13));
      if (c == 14) begin
        chk("col_wt_addr", mem_addr, 16'h0050);
        chk("col_wt_wr", mem_wr, 1);
      end
    end
    step_begin(); wt_req = 1'b0;
    @(negedge clk);
    chk("col_after_ack", wt_ack, 0);

    // Variable latency: 6-cycle latency plus a 2-cycle gap after word 3
    mem_lat = 6; mem_gap = 2; n_wr = 0;
    step_begin(); miss_detected = 1'b1; miss_address = 16'h4A5C;
    @(negedge clk);
    chk("vl_c0_busy", fsm_busy, 0);
    for (int c = 1; c <= 17; c++) begin
      logic exp_wda;
      step_begin();
      if (c == 1) miss_detected = 1'b0;
      @(negedge clk);
      exp_wda = (c >= 7 && c <= 10) || (c >= 13 && c <= 16);
      chk("vl_wda", write_data_array, exp_wda);
      if (write_data_array) n_wr++;
      if (exp_wda) begin
        chk("vl_fw", fill_word, (c <= 10) ? c - 7 : c - 9);
        chk("vl_fd", fill_data,
            16'(16'h4A50 + 16'(2 * ((c <= 10) ? c - 7 : c - 9))) ^ 16'h5A5A);
      end
      chk("vl_tag", write_tag_array, (c == 16));
      chk("vl_busy", fsm_busy, (c <= 16));
    end
    chk("vl_count", n_wr, 8);
    mem_lat = 4; mem_gap = 0;

    // Reset in the middle of a fill after three returns
    step_begin(); miss_detected = 1'b1; miss_address = 16'h3000;
    @(negedge clk);
    for (int c = 1; c <= 7; c++) begin
      step_begin();
      if (c == 1) miss_detected = 1'b0;
      @(negedge clk);
    end
    chk("mid_fw_before", fill_word, 2);
    chk("mid_wda_before", write_data_array, 1);
    step_begin(); rst = 1'b1;
    @(negedge clk);
    step_begin(); rst = 1'b0;
    @(negedge clk);
    chk_idle("mid_rst");
    step_begin();
    @(negedge clk);
    chk_idle("mid_rst2");

    // Fill at the top of the address space: no wrap within the block
    step_begin(); miss_detected = 1'b1; miss_address = 16'hFFF0;
    @(negedge clk);
    chk("top_c0_busy", fsm_busy, 0);
    check_fill("top", 16'hFFF0, 1'b0, 16'h0);

    // Back-to-back misses with miss_detected held through completion
    step_begin(); miss_detected = 1'b1; miss_address = 16'h7008;
    @(negedge clk);
    chk("b2b_c0_busy", fsm_busy, 0);
    check_fill("b2b1", 16'h7000, 1'b1, 16'h7012);
    check_fill("b2b2", 16'h7010, 1'b0, 16'h0);
    step_begin();
    @(negedge clk);
    chk_idle("b2b_end");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Miss-handling initiator on the cache side of the multi-cycle memory interface.
- On a cache miss it fetches one 16-byte block as 8 pipelined word reads, one issued per cycle.
- It counts the delayed data_valid returns and streams each word into the cache data array, then writes the tag.
- When idle it forwards single-cycle write-through stores to memory.

Parameters:
DWIDTH, 16, memory data width (bits per word)
AWIDTH, 16, byte address width
WORDS, 8, words per cache block (power of 2; block = 2*WORDS bytes)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
miss_detected  input  1  level; cache holds high until fsm_busy falls
miss_address  input  AWIDTH  byte address of missing access; low log2(2*WORDS) bits ignored
wt_req  input  1  write-through store request (level, held until wt_ack)
wt_addr  input  AWIDTH  store byte address; bit 0 must be 0
wt_data  input  DWIDTH  store data
wt_ack  output  1  store issued to memory this cycle
fsm_busy  output  1  fill in progress; cache stalls the pipeline
mem_enable  output  1  memory enable
mem_wr  output  1  memory write (1) / read (0)
mem_addr  output  AWIDTH  memory byte address
mem_data_in  output  DWIDTH  memory write data (= wt_data)
mem_data_out  input  DWIDTH  memory read data
mem_data_valid  input  1  memory read-return strobe
write_data_array  output  1  write fill_data to word fill_word of the victim line
fill_word  output  log2(WORDS)  word index within block
fill_data  output  DWIDTH  word to write (= mem_data_out)
write_tag_array  output  1  write tag/valid for miss block (one cycle)

Behaviour:
- States: IDLE, ISSUE, DRAIN. The state register, base_addr, issue_cnt and recv_cnt are all registered. fsm_busy = (state != IDLE).
- Reset: state IDLE, counters 0. All outputs 0: mem_enable, mem_wr, wt_ack, write_data_array, write_tag_array, fsm_busy, mem_addr, fill_word.
- Reset mid-fill aborts the fill; no tag write. The memory pipeline shares rst, so no stale valids follow.
- IDLE, wt_req=1:
  - Drive mem_enable=1, mem_wr=1, mem_addr=wt_addr, wt_ack=1 combinationally.
  - Stay in IDLE. This applies even when miss_detected=1: write wins, and the miss is accepted on the next IDLE cycle.
- IDLE, miss_detected=1, wt_req=0:
  - Latch base_addr = miss_address with the low offset bits cleared; issue_cnt=0, recv_cnt=0.
  - Go to ISSUE. No memory access this cycle.
- ISSUE:
  - Drive mem_enable=1, mem_wr=0, mem_addr = base_addr + 2*issue_cnt; issue_cnt increments each cycle.
  - After the issue with issue_cnt=WORDS-1, go to DRAIN.
  - Exactly WORDS consecutive read cycles, addresses base+0, +2, ..., +14.
- ISSUE and DRAIN, returns:
  - Each cycle mem_data_valid=1: write_data_array=1, fill_word=recv_cnt, fill_data=mem_data_out; recv_cnt increments.
  - Returns overlap ISSUE; memory latency is 4 cycles, but the block counts strobes and does not depend on latency.
- DRAIN:
  - mem_enable=0.
  - On the WORDS-th valid: write_tag_array=1 in the same cycle, next state IDLE.
  - fsm_busy falls the following cycle.
- wt_req while busy: wt_ack=0; the request waits.
- mem_data_valid in IDLE: ignored; no array writes.
- miss_detected still high on the first IDLE cycle after a fill: accepted as a new miss. The cache deasserts it once the tag write hits.
- Timeline (miss accepted at edge 0): reads in cycles 1-8, returns in cycles 5-12, tag write in cycle 12, busy low in cycle 13.
- recv_cnt and issue_cnt are log2(WORDS)+1 bits wide. Address arithmetic is modulo 2^AWIDTH; block alignment means no wrap within a block.

Test Plan:
- Basic fill: miss_address=0x1236 with a 4-cycle memory model → reads at 0x1230..0x123E in cycles 1-8. write_data_array in cycles 5-12 with fill_word 0..7 and correct data. write_tag_array in cycle 12 only; fsm_busy high cycles 1-12.
- Write-through when idle: wt_req, wt_addr=0x00A4, wt_data=0xBEEF → same cycle mem_enable=1, mem_wr=1, mem_addr=0x00A4, wt_ack=1; fsm_busy stays 0.
- Collision: wt_req and miss_detected together in IDLE → write issued first (wt_ack=1); fill reads begin 2 cycles later. A second wt_req during the fill → wt_ack=0 until the cycle after fsm_busy falls.
- Variable latency: memory model with 6-cycle latency and a 2-cycle gap in returns → still exactly 8 data writes with fill_word 0..7; tag write on the 8th valid.
- Reset mid-fill: rst=1 after 3 returns → next cycle all outputs 0 and state IDLE. A new miss at 0xFFF0 reads 0xFFF0..0xFFFE with no address wrap.
- Back-to-back misses: miss_detected held high through fill completion → second fill starts at IDLE+1; counters restart at 0.
